// File: rtl/store_buffer.sv
// store_buffer: aligns MEM-stage stores to the word, builds byte enables,
// rejects misaligned stores with a one-cycle exception pulse and queues the
// aligned writes in a small in-order FIFO that drains into data memory.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_addr,
    input  logic [31:0]              in_data,
    input  logic [1:0]               st_op,
    output logic                     dm_valid,
    input  logic                     dm_ready,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wdata,
    output logic [3:0]               dm_be,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     st_exc,
    output logic [31:0]              exc_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {
        OpSw  = 2'b00,
        OpSb  = 2'b01,
        OpSh  = 2'b10,
        OpRsv = 2'b11
    } st_op_e;

    // Entry storage; no reset needed since occupancy comes from the pointers
    logic [29:0] ent_word_q [DEPTH];
    logic [31:0] ent_data_q [DEPTH];
    logic [3:0]  ent_be_q   [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          st_exc_q, st_exc_d;
    logic [31:0]   exc_addr_q, exc_addr_d;

    logic          accept, push, pop;
    logic          misaligned, storable;
    logic [3:0]    new_be;
    logic [31:0]   new_data;
    logic [PW-1:0] off;

    assign in_ready = (count_q < FullCount) & reset;
    assign accept   = in_valid & in_ready;
    assign push     = accept & storable;
    assign dm_valid = (count_q != '0);
    assign pop      = dm_valid & dm_ready;

    // Decode the store size into lane enables, replicated data and misalignment
    always_comb begin
        new_be     = '0;
        new_data   = '0;
        misaligned = 1'b0;
        storable   = 1'b0;
        unique case (st_op_e'(st_op))
            OpSw: begin
                new_be     = 4'b1111;
                new_data   = in_data;
                misaligned = (in_addr[1:0] != 2'b00);
                storable   = !misaligned;
            end
            OpSh: begin
                new_be     = in_addr[1] ? 4'b1100 : 4'b0011;
                new_data   = {2{in_data[15:0]}};
                misaligned = in_addr[0];
                storable   = !misaligned;
            end
            OpSb: begin
                new_be     = 4'b0001 << in_addr[1:0];
                new_data   = {4{in_data[7:0]}};
                storable   = 1'b1;
            end
            OpRsv: begin
                // reserved encoding is consumed and dropped silently
            end
        endcase
    end

    // Next-state for pointers, occupancy and the exception pulse
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        st_exc_d   = accept & misaligned;
        exc_addr_d = exc_addr_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (accept & misaligned) begin
            exc_addr_d = in_addr;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            st_exc_q   <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            st_exc_q   <= st_exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Write the aligned store into the tail slot
    always_ff @(posedge clk) begin
        if (push) begin
            ent_word_q[wptr_q] <= in_addr[31:2];
            ent_data_q[wptr_q] <= new_data;
            ent_be_q[wptr_q]   <= new_be;
        end
    end

    // Word-match of the in-flight load against occupied slots only
    always_comb begin
        ld_hazard = 1'b0;
        off       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PW'(i) - rptr_q;
            if (({1'b0, off} < count_q) && (ent_word_q[i] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    // Head presentation; zeroed when empty so DM never sees stale lanes
    always_comb begin
        dm_addr  = '0;
        dm_wdata = '0;
        dm_be    = '0;
        if (dm_valid) begin
            dm_addr  = {ent_word_q[rptr_q], 2'b00};
            dm_wdata = ent_data_q[rptr_q];
            dm_be    = ent_be_q[rptr_q];
        end
    end

    assign st_exc   = st_exc_q;
    assign exc_addr = exc_addr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the store buffer.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  st_op;
    logic        dm_valid;
    logic        dm_ready;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        st_exc;
    logic [31:0] exc_addr;
    logic [2:0]  count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .st_op     (st_op),
        .dm_valid  (dm_valid),
        .dm_ready  (dm_ready),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .st_exc    (st_exc),
        .exc_addr  (exc_addr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    logic        m_exc;
    logic [31:0] m_exc_addr;
    int          n_cmp;
    int          n_err;
    logic        chk_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, compare against the model, advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] op, input logic rdy, input logic [31:0] la,
                        input logic rst);
        logic        e_rdy;
        logic        e_haz;
        logic        acc;
        int unsigned lane;
        ent_t        e;
        @(negedge clk);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        st_op    = op;
        dm_ready = rdy;
        ld_addr  = la;
        reset    = rst;
        #1;
        e_rdy = (mq.size() < DEPTH) && rst;
        e_haz = 1'b0;
        foreach (mq[i]) if ((mq[i].addr / 4) == (la / 4)) e_haz = 1'b1;
        if (chk_on) begin
            check("in_ready", in_ready, e_rdy);
            check("count", count, mq.size());
            check("dm_valid", dm_valid, mq.size() != 0);
            check("dm_addr", dm_addr, mq.size() != 0 ? mq[0].addr : 0);
            check("dm_wdata", dm_wdata, mq.size() != 0 ? mq[0].data : 0);
            check("dm_be", dm_be, mq.size() != 0 ? mq[0].be : 0);
            check("ld_hazard", ld_hazard, e_haz);
            check("st_exc", st_exc, m_exc);
            check("exc_addr", exc_addr, m_exc_addr);
        end
        acc = v && e_rdy;
        if (!rst) begin
            mq.delete();
            m_exc      = 1'b0;
            m_exc_addr = '0;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            m_exc = 1'b0;
            if (acc) begin
                lane   = a % 4;
                e.addr = a - lane;
                case (op)
                    2'b00: begin
                        e.be = 4'hF;
                        e.data = d;
                        if (lane != 0) begin
                            m_exc = 1'b1;
                            m_exc_addr = a;
                        end else mq.push_back(e);
                    end
                    2'b10: begin
                        e.be = (lane >= 2) ? 4'hC : 4'h3;
                        e.data = (d % 65536) * 32'h0001_0001;
                        if (lane % 2 != 0) begin
                            m_exc = 1'b1;
                            m_exc_addr = a;
                        end else mq.push_back(e);
                    end
                    2'b01: begin
                        e.be = 4'(1 << lane);
                        e.data = (d % 256) * 32'h0101_0101;
                        mq.push_back(e);
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic rdy, input logic [31:0] la);
        step(1'b0, 32'h0, 32'h0, 2'b00, rdy, la, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_exc = 1'b0;
        m_exc_addr = '0;
        chk_on = 1'b0;
        in_valid = 0; in_addr = 0; in_data = 0; st_op = 0;
        dm_ready = 0; ld_addr = 0; reset = 0;

        // Power-on reset, then reset-state check
        step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        chk_on = 1'b1;
        step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        check("rst_count", count, 0);
        check("rst_dm_valid", dm_valid, 0);

        // Single sb at 0x1003
        step(1'b1, 32'h1003, 32'h0000_00A5, 2'b01, 1'b1, 32'h0, 1'b1);
        #1;
        check("sb_valid", dm_valid, 1);
        check("sb_addr", dm_addr, 32'h1000);
        check("sb_be", dm_be, 4'b1000);
        check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
        idle(1'b1, 32'h0);
        #1;
        check("sb_drained", count, 0);

        // sh then sw held, hazard checks, then ordered drain
        step(1'b1, 32'h2002, 32'h0000_1234, 2'b10, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h2004, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0, 1'b1);
        #1;
        check("two_count", count, 2);
        check("sh_be", dm_be, 4'b1100);
        check("sh_wdata", dm_wdata, 32'h1234_1234);
        idle(1'b0, 32'h2006);
        #1;
        check("haz_hit", ld_hazard, 1);
        idle(1'b0, 32'h2008);
        #1;
        check("haz_miss", ld_hazard, 0);
        idle(1'b1, 32'h0);
        #1;
        check("order_sw_addr", dm_addr, 32'h2004);
        check("order_sw_data", dm_wdata, 32'hDEAD_BEEF);
        idle(1'b1, 32'h0);

        // Misaligned stores
        step(1'b1, 32'h3001, 32'h1111_1111, 2'b00, 1'b0, 32'h0, 1'b1);
        #1;
        check("mis_sw_exc", st_exc, 1);
        check("mis_sw_addr", exc_addr, 32'h3001);
        check("mis_sw_count", count, 0);
        step(1'b1, 32'h3003, 32'h2222_2222, 2'b10, 1'b0, 32'h0, 1'b1);
        #1;
        check("mis_sh_exc", st_exc, 1);
        check("mis_sh_addr", exc_addr, 32'h3003);
        step(1'b1, 32'h3002, 32'h3333_3333, 2'b10, 1'b0, 32'h0, 1'b1);
        #1;
        check("ok_sh_exc", st_exc, 0);
        check("ok_sh_count", count, 1);
        idle(1'b1, 32'h0);

        // Fill, hold a 5th, then stream push+pop across pointer wrap
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h6000 + 4 * i, 32'hC000_0000 + i, 2'b00, 1'b0, 32'h0, 1'b1);
        #1;
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        step(1'b1, 32'h6010, 32'hC000_0004, 2'b00, 1'b0, 32'h0, 1'b1);
        #1;
        check("full_held", count, 4);
        step(1'b1, 32'h6010, 32'hC000_0004, 2'b00, 1'b1, 32'h0, 1'b1);
        #1;
        check("stream_first", count, 3);
        for (int i = 4; i < 8; i++) begin
            step(1'b1, 32'h6000 + 4 * i, 32'hC000_0000 + i, 2'b00, 1'b1, 32'h0, 1'b1);
            #1;
            check("stream_steady", count, 3);
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 32'h0);

        // Reset with entries pending
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h7000 + 4 * i, 32'h7700_0000 + i, 2'b01, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b0);
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", dm_valid, 0);
        idle(1'b1, 32'h7000);
        idle(1'b1, 32'h7000);

        // Reserved op dropped
        step(1'b1, 32'h4000, 32'h4444_4444, 2'b11, 1'b0, 32'h0, 1'b1);
        #1;
        check("rsv_count", count, 0);
        check("rsv_exc", st_exc, 0);

        // Randomized traffic over a small address window to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, 32'h5000 + $urandom_range(0, 31), $urandom,
                 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                 32'h5000 + $urandom_range(0, 31), $urandom_range(0, 99) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load extender: aligns store data to the word, generates byte enables for sw/sh/sb, flags misaligned stores, and queues the aligned writes in a small FIFO that drains into data memory through a valid/ready port. Sits between the MEM-stage store path and DM. The load path uses its hazard output to stall a load that targets a word with a pending store.

## Interface
- DEPTH, 4, number of FIFO entries (power of two, ≥2)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- in_valid  input  1  store request present
- in_ready  output  1  buffer can accept a request this cycle
- in_addr  input  32  byte address of the store
- in_data  input  32  register value to store (low bits used for sh/sb)
- st_op  input  2  00 sw, 01 sb, 10 sh, 11 reserved
- dm_valid  output  1  head entry presented to DM
- dm_ready  input  1  DM accepts head entry this cycle
- dm_addr  output  32  word address of head, {addr[31:2], 2'b00}
- dm_wdata  output  32  aligned write data of head
- dm_be  output  4  byte enables of head (bit i = byte i)
- ld_addr  input  32  address of the load currently in MEM
- ld_hazard  output  1  a queued entry targets the same word as ld_addr
- st_exc  output  1  one-cycle pulse: misaligned store was rejected
- exc_addr  output  32  byte address of the last rejected store
- count  output  log2(DEPTH)+1  number of occupied entries

## Operation
- Accept: in_valid & in_ready. in_ready = (count < DEPTH) & reset.
- Alignment, with a = in_addr[1:0]:
  - sw: be = 1111, data = in_data.
  - sh: be = a[1] ? 1100 : 0011, data = {2{in_data[15:0]}}.
  - sb: be = 0001 << a, data = {4{in_data[7:0]}}.
- Misalignment: sw with a≠00, or sh with a[0]=1.
  - The request is accepted but not enqueued.
  - st_exc = 1 in the next cycle; exc_addr = in_addr.
- st_op = 11: accepted and dropped. No enqueue, no exception.
- Drain: when dm_valid & dm_ready, the head is popped. dm_valid = (count ≠ 0).
- When the buffer is empty, dm_addr, dm_wdata and dm_be read 0.
- FIFO order: entries reach DM strictly in acceptance order. No merging of entries.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- ld_hazard is combinational: 1 if any occupied entry has addr[31:2] == ld_addr[31:2].
  - Only stored entries are compared, not the request being accepted in the same cycle.
- Reset (reset=0 at an edge):
  - count, pointers, dm_valid, st_exc and exc_addr are cleared to 0.
  - Pending entries are discarded.
  - While reset=0, in_ready=0.

## Timing
- Enqueue to DM: an entry accepted at edge N is first visible on dm_* after edge N (latency 1). There is no combinational pass-through from in_* to dm_*.
- Simultaneous accept and pop: count unchanged. This is legal at any count except full, because in_ready=0 when full even if dm_ready=1.
- Full (count = DEPTH): in_ready=0, and in_* is ignored.
- Empty (count = 0): dm_valid=0, and dm_ready is ignored.
- st_exc is high for exactly one cycle per rejected store. Back-to-back misaligned stores give back-to-back pulses, and exc_addr updates each cycle.
- A misaligned request is accepted only when in_ready=1. When full it waits like any other store.
- The head must remain stable while dm_valid & !dm_ready.
- Reset asserted mid-drain: dm_valid=0 in the cycle after the reset edge. A dm_ready in that cycle has no effect.
- Wrap-around: after DEPTH pushes and pops, pointers return to 0 with no gap in ordering.

## Test plan
- Single sb 0x000000A5 at 0x1003, dm_ready=1 → next cycle dm_valid=1, dm_addr=0x1000, dm_be=1000, dm_wdata=0xA5A5A5A5; the cycle after, count=0.
- sh 0x1234 at 0x2002, then sw 0xDEADBEEF at 0x2004, with dm_ready=0 → count=2, head be=1100, wdata=0x12341234; ld_addr=0x2006 gives ld_hazard=1, ld_addr=0x2008 gives ld_hazard=0. Release dm_ready → order is sh then sw.
- sw at 0x3001 → not queued (count stays 0), st_exc=1 for one cycle, exc_addr=0x3001. sh at 0x3003 → same behaviour. sh at 0x3002 → queued, no exception.
- Fill DEPTH=4 with dm_ready=0 → count=4, in_ready=0, and a 5th request is held. Then dm_ready=1 with in_valid=1 continuously → count goes 3, then remains 3 (one push and one pop per cycle). Push 8 distinct stores in total → DM receives them in order across pointer wrap.
- Three entries queued, then reset=0 for one edge → count=0, dm_valid=0, in_ready=0 during reset and 1 afterwards; no stale entry reaches DM afterwards.
- st_op=11 at 0x4000 → count unchanged, st_exc=0.
